// File: rtl/clock_pkg.sv
// Shared definitions for the minute/hour stage of the digital clock:
// set-mode state encoding, BCD field limits and digit width.
package clock_pkg;

    localparam int DIGIT_W = 4;

    // Highest legal value of each two-digit BCD field
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

    // Encoding is exposed directly on set_mode; 2'b11 is unused
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_MIN  = 2'b01,
        ST_SET_HOUR = 2'b10
    } state_e;

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit BCD counter that counts 00..MAX and wraps to 00.
// An increment applied to an illegal value (a digit above 9, or a value
// above MAX) loads 00 and produces no wrap pulse.
module bcd2_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX       = 8'h59,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               load_zero_illegal,
    output logic [DIGIT_W-1:0] lo,
    output logic [DIGIT_W-1:0] hi,
    output logic               wrap
);

    logic [DIGIT_W-1:0] lo_q, lo_d;
    logic [DIGIT_W-1:0] hi_q, hi_d;
    logic               legal;

    // Next-value logic: BCD increment with modulo wrap and illegal recovery
    always_comb begin
        lo_d  = lo_q;
        hi_d  = hi_q;
        wrap  = 1'b0;
        legal = (lo_q <= 4'd9) && (hi_q <= 4'd9) && ({hi_q, lo_q} <= MAX);
        if (inc) begin
            if (!legal) begin
                if (load_zero_illegal) begin
                    lo_d = 4'd0;
                    hi_d = 4'd0;
                end
            end else if ({hi_q, lo_q} == MAX) begin
                lo_d = 4'd0;
                hi_d = 4'd0;
                wrap = 1'b1;
            end else if (lo_q == 4'd9) begin
                lo_d = 4'd0;
                hi_d = hi_q + 4'd1;
            end else begin
                lo_d = lo_q + 4'd1;
            end
        end
    end

    // Digit registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_q <= RESET_VAL[3:0];
            hi_q <= RESET_VAL[7:4];
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;

endmodule

// File: rtl/minute_hour_counter.sv
// Minutes/hours stage of the digital clock. Counts minute carries from the
// seconds stage in RUN, lets the user set minutes and hours with button
// pulses, and pulses day_co when the time rolls over from 23:59 to 00:00.
module minute_hour_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] RESET_MIN = 8'h00,
    parameter logic [7:0] RESET_HR  = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sec_co,
    input  logic               start,
    input  logic               mode_btn,
    input  logic               inc_btn,
    output logic [DIGIT_W-1:0] min_lo,
    output logic [DIGIT_W-1:0] min_hi,
    output logic [DIGIT_W-1:0] hr_lo,
    output logic [DIGIT_W-1:0] hr_hi,
    output logic               day_co,
    output logic [1:0]         set_mode
);

    state_e state_q;
    logic   day_co_q;
    logic   tick;
    logic   set_inc;
    logic   min_inc, hr_inc;
    logic   min_wrap, hr_wrap;

    // Carry gating: a running minute tick, or a set-mode increment that is
    // not overridden by a simultaneous mode press
    always_comb begin
        tick    = (state_q == ST_RUN) && sec_co && !start;
        set_inc = inc_btn && !mode_btn;
        min_inc = tick || ((state_q == ST_SET_MIN) && set_inc);
        hr_inc  = (tick && min_wrap) || ((state_q == ST_SET_HOUR) && set_inc);
    end

    bcd2_mod_counter #(
        .MAX       (MIN_MAX),
        .RESET_VAL (RESET_MIN)
    ) u_min (
        .clk               (clk),
        .reset             (reset),
        .inc               (min_inc),
        .load_zero_illegal (1'b1),
        .lo                (min_lo),
        .hi                (min_hi),
        .wrap              (min_wrap)
    );

    bcd2_mod_counter #(
        .MAX       (HR_MAX),
        .RESET_VAL (RESET_HR)
    ) u_hr (
        .clk               (clk),
        .reset             (reset),
        .inc               (hr_inc),
        .load_zero_illegal (1'b1),
        .lo                (hr_lo),
        .hi                (hr_hi),
        .wrap              (hr_wrap)
    );

    // Set-mode FSM and registered day carry; unused encoding recovers to RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            day_co_q <= 1'b0;
        end else begin
            day_co_q <= tick && min_wrap && hr_wrap;
            case (state_q)
                ST_RUN:      if (mode_btn) state_q <= ST_SET_MIN;
                ST_SET_MIN:  if (mode_btn) state_q <= ST_SET_HOUR;
                ST_SET_HOUR: if (mode_btn) state_q <= ST_RUN;
                default:     state_q <= ST_RUN;
            endcase
        end
    end

    assign day_co   = day_co_q;
    assign set_mode = state_q;

endmodule
